mux_n_scan: RTL and testbench

Parametrised N-channel, WIDTH-bit multiplexer with a registered output and two select modes. In manual mode it holds a channel loaded from a port. In scan mode an internal counter steps through every channel, dwelling a fixed number of cycles on each. It replaces the fixed 2:1 4-bit mux in the datapath wherever a registered, channel-tagged, self-scanning selection is needed, such as display multiplexing or sampling several registers onto one bus.

---
 rtl/mux_n_scan_pkg.sv | 26 ++
 rtl/mux_n_comb.sv | 24 ++
 rtl/mux_n_scan.sv | 126 ++++++++++++
 tb/tb_mux_n_scan.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/mux_n_scan_pkg.sv
// rtl/mux_n_scan_pkg.sv - shared encodings for the scanning N:1 multiplexer
package mux_n_scan_pkg;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MANUAL = 2'd1,
    SCAN   = 2'd2
  } state_e;

  // The operating state is a pure function of enable and mode on each edge.
  function automatic state_e decode_state(input logic enable, input logic mode);
    if (!enable) begin
      return IDLE;
    end else if (mode == MODE_SCAN) begin
      return SCAN;
    end else begin
      return MANUAL;
    end
  endfunction

endpackage

// File: rtl/mux_n_comb.sv
// rtl/mux_n_comb.sv - purely combinational N:1 WIDTH-bit channel selector
module mux_n_comb
  #(
    parameter int WIDTH = 4,
    parameter int N     = 4,
    parameter int SW    = 2
  )
  (
    input  logic [N*WIDTH-1:0] in_bus,
    input  logic [SW-1:0]      sel,
    output logic [WIDTH-1:0]   data
  );

  // Indices at or beyond N (non power-of-two N) resolve to zero.
  always_comb begin
    data = '0;
    for (int i = 0; i < N; i++) begin
      if (sel == SW'(i)) begin
        data = in_bus[i*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/mux_n_scan.sv
// rtl/mux_n_scan.sv - registered N-channel mux with manual select and self-scanning mode
module mux_n_scan
  import mux_n_scan_pkg::*;
  #(
    parameter int   WIDTH = 4,
    parameter int   N     = 4,
    parameter int   DWELL = 1,
    localparam int  SW    = (N > 1) ? $clog2(N) : 1
  )
  (
    input  logic               clk,
    input  logic               reset,
    input  logic [N*WIDTH-1:0] in_bus,
    input  logic [SW-1:0]      sel,
    input  logic               sel_load,
    input  logic               mode,
    input  logic               enable,
    output logic [WIDTH-1:0]   out,
    output logic [SW-1:0]      out_ch,
    output logic               out_valid,
    output logic               wrap,
    output logic               sel_err
  );

  localparam int          DW         = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
  localparam logic [SW:0]   N_EXT      = (SW + 1)'(N);
  localparam logic [SW-1:0] LAST_CH    = SW'(N - 1);

  state_e          state;
  state_e          next_state;
  logic [DW-1:0]   dwell;
  logic [DW-1:0]   next_dwell;
  logic [DW-1:0]   dwell_base;
  logic [SW-1:0]   next_ch;
  logic            next_wrap;
  logic            next_err;
  logic            sel_in_range;
  logic            sel_ok;
  logic [WIDTH-1:0] sel_data;

  assign sel_in_range = ({1'b0, sel} < N_EXT);
  assign sel_ok       = sel_load && sel_in_range;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Behaviour on each edge follows the state being entered, so a mode change
  // and a sel_load on the same edge use the new mode's rules.
  always_comb begin
    next_state = decode_state(enable, mode);
    next_ch    = out_ch;
    next_dwell = dwell;
    next_wrap  = 1'b0;
    next_err   = 1'b0;
    dwell_base = (state == MANUAL) ? '0 : dwell;
    case (next_state)
      MANUAL: begin
        next_dwell = '0;
        next_err   = sel_load && !sel_in_range;
        if (sel_ok) begin
          next_ch = sel;
        end
      end
      SCAN: begin
        next_err = sel_load && !sel_in_range;
        if (sel_ok) begin
          next_ch    = sel;
          next_dwell = '0;
        end else if (dwell_base == DWELL_LAST) begin
          next_dwell = '0;
          if (out_ch == LAST_CH) begin
            next_ch   = '0;
            next_wrap = 1'b1;
          end else begin
            next_ch = out_ch + SW'(1);
          end
        end else begin
          next_dwell = dwell_base + DW'(1);
        end
      end
      default: begin
        next_ch    = out_ch;
        next_dwell = dwell;
      end
    endcase
  end

  mux_n_comb #(
    .WIDTH (WIDTH),
    .N     (N),
    .SW    (SW)
  ) u_mux (
    .in_bus (in_bus),
    .sel    (next_ch),
    .data   (sel_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out       <= '0;
      out_ch    <= '0;
      dwell     <= '0;
      out_valid <= 1'b0;
      wrap      <= 1'b0;
      sel_err   <= 1'b0;
    end else if (next_state != IDLE) begin
      out       <= sel_data;
      out_ch    <= next_ch;
      dwell     <= next_dwell;
      out_valid <= 1'b1;
      wrap      <= next_wrap;
      sel_err   <= next_err;
    end else begin
      out_valid <= 1'b0;
      wrap      <= 1'b0;
      sel_err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_n_scan.sv
// tb/tb_mux_n_scan.sv - table-driven self-checking bench for mux_n_scan
module tb_mux_n_scan;

  logic        clk = 1'b0;
  logic        reset;

  logic [15:0] bus_a;
  logic [1:0]  sel_a;
  logic        load_a, mode_a, en_a;
  logic [3:0]  out_a;
  logic [1:0]  ch_a;
  logic        valid_a, wrap_a, err_a;

  logic [11:0] bus_b;
  logic [1:0]  sel_b;
  logic        load_b, mode_b, en_b;
  logic [3:0]  out_b;
  logic [1:0]  ch_b;
  logic        valid_b, wrap_b, err_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mux_n_scan #(.WIDTH(4), .N(4), .DWELL(2)) dut_a (
    .clk(clk), .reset(reset), .in_bus(bus_a), .sel(sel_a), .sel_load(load_a),
    .mode(mode_a), .enable(en_a), .out(out_a), .out_ch(ch_a),
    .out_valid(valid_a), .wrap(wrap_a), .sel_err(err_a)
  );

  mux_n_scan #(.WIDTH(4), .N(3), .DWELL(1)) dut_b (
    .clk(clk), .reset(reset), .in_bus(bus_b), .sel(sel_b), .sel_load(load_b),
    .mode(mode_b), .enable(en_b), .out(out_b), .out_ch(ch_b),
    .out_valid(valid_b), .wrap(wrap_b), .sel_err(err_b)
  );

  typedef struct {
    logic        en;
    logic        mode;
    logic        load;
    logic [1:0]  sel;
    logic [15:0] bus;
    logic [3:0]  e_out;
    logic [1:0]  e_ch;
    logic        e_valid;
    logic        e_wrap;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic en, input logic mode, input logic load, input logic [1:0] sel,
                     input logic [15:0] bus, input logic [3:0] e_out, input logic [1:0] e_ch,
                     input logic e_valid, input logic e_wrap);
    vec_t v;
    v.en = en; v.mode = mode; v.load = load; v.sel = sel; v.bus = bus;
    v.e_out = e_out; v.e_ch = e_ch; v.e_valid = e_valid; v.e_wrap = e_wrap;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_a(input string tag, input logic [3:0] e_out, input logic [1:0] e_ch,
                         input logic e_valid, input logic e_wrap);
    check({tag, " out"},     16'(out_a),   16'(e_out));
    check({tag, " out_ch"},  16'(ch_a),    16'(e_ch));
    check({tag, " valid"},   16'(valid_a), 16'(e_valid));
    check({tag, " wrap"},    16'(wrap_a),  16'(e_wrap));
    check({tag, " sel_err"}, 16'(err_a),   16'(1'b0));
  endtask

  task automatic step_b(input string tag, input logic en, input logic mode, input logic load,
                        input logic [1:0] sel, input logic [3:0] e_out, input logic [1:0] e_ch,
                        input logic e_valid, input logic e_wrap, input logic e_err);
    @(negedge clk);
    en_b = en; mode_b = mode; load_b = load; sel_b = sel;
    @(posedge clk);
    #1;
    check({tag, " out"},     16'(out_b),   16'(e_out));
    check({tag, " out_ch"},  16'(ch_b),    16'(e_ch));
    check({tag, " valid"},   16'(valid_b), 16'(e_valid));
    check({tag, " wrap"},    16'(wrap_b),  16'(e_wrap));
    check({tag, " sel_err"}, 16'(err_b),   16'(e_err));
  endtask

  localparam logic [15:0] B = 16'h3210;

  initial begin
    reset = 1'b1;
    bus_a = B;      sel_a = '0; load_a = 1'b0; mode_a = 1'b0; en_a = 1'b0;
    bus_b = 12'h975; sel_b = '0; load_b = 1'b0; mode_b = 1'b0; en_b = 1'b0;

    // Manual load, data tracking, then a DWELL=2 scan with wrap, idle hold and resume.
    add(1, 0, 1, 2, B,        4'h2, 2, 1, 0);
    add(1, 0, 0, 0, B,        4'h2, 2, 1, 0);
    add(1, 0, 0, 0, 16'h3A10, 4'hA, 2, 1, 0);
    add(1, 0, 1, 0, B,        4'h0, 0, 1, 0);
    add(1, 1, 0, 0, B,        4'h0, 0, 1, 0);
    add(1, 1, 0, 0, B,        4'h1, 1, 1, 0);
    add(1, 1, 0, 0, B,        4'h1, 1, 1, 0);
    add(1, 1, 0, 0, B,        4'h2, 2, 1, 0);
    add(1, 1, 0, 0, B,        4'h2, 2, 1, 0);
    add(1, 1, 0, 0, B,        4'h3, 3, 1, 0);
    add(1, 1, 0, 0, B,        4'h3, 3, 1, 0);
    add(1, 1, 0, 0, B,        4'h0, 0, 1, 1);
    add(1, 1, 0, 0, B,        4'h0, 0, 1, 0);
    add(1, 1, 0, 0, B,        4'h1, 1, 1, 0);
    add(1, 1, 0, 0, B,        4'h1, 1, 1, 0);
    for (int k = 0; k < 5; k++) add(0, 1, 1, 3, 16'hFFFF, 4'h1, 1, 0, 0);
    add(1, 1, 0, 0, B,        4'h2, 2, 1, 0);
    add(1, 1, 0, 0, B,        4'h2, 2, 1, 0);
    add(1, 1, 1, 3, B,        4'h3, 3, 1, 0);
    add(1, 1, 0, 0, B,        4'h3, 3, 1, 0);
    add(1, 1, 1, 0, B,        4'h0, 0, 1, 0);
    add(1, 1, 0, 0, B,        4'h0, 0, 1, 0);
    add(1, 1, 0, 0, B,        4'h1, 1, 1, 0);
    add(1, 1, 0, 0, B,        4'h1, 1, 1, 0);

    repeat (2) @(posedge clk);
    #1;
    check_a("reset_a", 4'h0, 0, 0, 0);
    check("reset_b out",    16'(out_b),   16'h0);
    check("reset_b out_ch", 16'(ch_b),    16'h0);
    check("reset_b valid",  16'(valid_b), 16'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      en_a = vecs[i].en; mode_a = vecs[i].mode; load_a = vecs[i].load;
      sel_a = vecs[i].sel; bus_a = vecs[i].bus;
      @(posedge clk);
      #1;
      check_a($sformatf("vec%0d", i), vecs[i].e_out, vecs[i].e_ch, vecs[i].e_valid, vecs[i].e_wrap);
    end

    // Asynchronous reset mid-dwell at channel 1: outputs clear before any edge.
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_a("async_reset", 4'h0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    en_a = 1'b1; mode_a = 1'b1; load_a = 1'b0; bus_a = B;
    @(posedge clk);
    #1;
    check_a("post_reset0", 4'h0, 0, 1, 0);
    @(posedge clk);
    #1;
    check_a("post_reset1", 4'h1, 1, 1, 0);

    // N=3, DWELL=1: out-of-range select flags sel_err and leaves selection alone.
    step_b("b_load1",   1, 0, 1, 1, 4'h7, 1, 1, 0, 0);
    step_b("b_err_man", 1, 0, 1, 3, 4'h7, 1, 1, 0, 1);
    step_b("b_hold",    1, 0, 0, 0, 4'h7, 1, 1, 0, 0);
    step_b("b_err_scn", 1, 1, 1, 3, 4'h9, 2, 1, 0, 1);
    step_b("b_wrap",    1, 1, 0, 0, 4'h5, 0, 1, 1, 0);
    step_b("b_idle",    0, 1, 1, 3, 4'h5, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
